// File: rtl/icache_port_sched.sv
// Shares the single I-Cache port between IFU demand fetches and the next-line
// prefetcher; splits line-crossing demand fetches and merges both lines into one beat.
module icache_port_sched #(
  parameter int VAddrBits       = 39,
  parameter int LINE_BYTES      = 64,
  parameter int DATA_WIDTH      = 512,
  parameter int PF_STARVE_LIMIT = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    dem_req_valid_i,
  output logic                    dem_req_ready_o,
  input  logic [VAddrBits-1:0]    dem_req_addr_i,
  input  logic                    dem_req_double_line_i,
  input  logic                    pf_req_valid_i,
  output logic                    pf_req_ready_o,
  input  logic [VAddrBits-1:0]    pf_req_addr_i,
  output logic                    cache_req_valid_o,
  input  logic                    cache_req_ready_i,
  output logic [VAddrBits-1:0]    cache_req_addr_o,
  input  logic                    cache_resp_valid_i,
  output logic                    cache_resp_ready_o,
  input  logic [DATA_WIDTH-1:0]   cache_resp_data_i,
  input  logic                    cache_resp_mmio_i,
  output logic                    dem_resp_valid_o,
  input  logic                    dem_resp_ready_i,
  output logic [2*DATA_WIDTH-1:0] dem_resp_data_o,
  output logic                    dem_resp_mmio_o,
  output logic                    pf_done_o
);

  localparam int CntW = $clog2(PF_STARVE_LIMIT + 1);
  localparam logic [CntW-1:0]      StarveMax = CntW'(PF_STARVE_LIMIT);
  localparam logic [VAddrBits-1:0] LineMask  = VAddrBits'(LINE_BYTES - 1);
  localparam logic [VAddrBits-1:0] LineStep  = VAddrBits'(LINE_BYTES);

  typedef enum logic [3:0] {
    IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP, PF_REQ, PF_WAIT, DRAIN
  } state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         starveCnt_q, starveCnt_d;
  logic [VAddrBits-1:0]    line0_q, line0_d;
  logic                    dbl_q, dbl_d;
  logic [VAddrBits-1:0]    pfAddr_q, pfAddr_d;
  logic [2*DATA_WIDTH-1:0] respData_q, respData_d;
  logic                    respMmio_q, respMmio_d;

  logic idleOpen, pfWins, pfGrant, demGrant, reqFire;

  // Prefetch only takes the port when demand is absent or it has starved long enough.
  assign idleOpen = (state_q == IDLE) && !flush_i;
  assign pfWins   = pf_req_valid_i && ((starveCnt_q == StarveMax) || !dem_req_valid_i);
  assign pfGrant  = idleOpen && pfWins;
  assign demGrant = idleOpen && dem_req_valid_i && !pfWins;
  assign reqFire  = cache_req_valid_o && cache_req_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      starveCnt_q <= '0;
      line0_q     <= '0;
      dbl_q       <= 1'b0;
      pfAddr_q    <= '0;
      respData_q  <= '0;
      respMmio_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      starveCnt_q <= starveCnt_d;
      line0_q     <= line0_d;
      dbl_q       <= dbl_d;
      pfAddr_q    <= pfAddr_d;
      respData_q  <= respData_d;
      respMmio_q  <= respMmio_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    starveCnt_d = starveCnt_q;
    line0_d     = line0_q;
    dbl_d       = dbl_q;
    pfAddr_d    = pfAddr_q;
    respData_d  = respData_q;
    respMmio_d  = respMmio_q;

    if (!pf_req_valid_i || pfGrant) begin
      starveCnt_d = '0;
    end else if (demGrant && (starveCnt_q != StarveMax)) begin
      starveCnt_d = starveCnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (pfGrant) begin
          pfAddr_d = pf_req_addr_i & ~LineMask;
          state_d  = PF_REQ;
        end else if (demGrant) begin
          line0_d = dem_req_addr_i & ~LineMask;
          dbl_d   = dem_req_double_line_i;
          state_d = REQ0;
        end
      end
      REQ0, REQ1, PF_REQ: begin
        // A request already handed to the cache still owes a response, so drain it.
        if (reqFire) begin
          if (flush_i)              state_d = DRAIN;
          else if (state_q == REQ0) state_d = WAIT0;
          else if (state_q == REQ1) state_d = WAIT1;
          else                      state_d = PF_WAIT;
        end else if (flush_i) begin
          state_d = IDLE;
        end
      end
      WAIT0: begin
        if (cache_resp_valid_i) begin
          if (flush_i) begin
            state_d = IDLE;
          end else begin
            respData_d[DATA_WIDTH-1:0] = cache_resp_data_i;
            respMmio_d                 = cache_resp_mmio_i;
            if (dbl_q && !cache_resp_mmio_i) begin
              state_d = REQ1;
            end else begin
              respData_d[2*DATA_WIDTH-1:DATA_WIDTH] = '0;
              state_d                               = RESP;
            end
          end
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end
      WAIT1: begin
        if (cache_resp_valid_i) begin
          if (flush_i) begin
            state_d = IDLE;
          end else begin
            respData_d[2*DATA_WIDTH-1:DATA_WIDTH] = cache_resp_data_i;
            state_d                               = RESP;
          end
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end
      PF_WAIT: begin
        if (cache_resp_valid_i)  state_d = IDLE;
        else if (flush_i)        state_d = DRAIN;
      end
      RESP: begin
        if (flush_i || dem_resp_ready_i) state_d = IDLE;
      end
      DRAIN: begin
        if (cache_resp_valid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dem_req_ready_o    = 1'b0;
    pf_req_ready_o     = 1'b0;
    cache_req_valid_o  = 1'b0;
    cache_req_addr_o   = '0;
    cache_resp_ready_o = 1'b0;
    dem_resp_valid_o   = 1'b0;
    pf_done_o          = 1'b0;
    case (state_q)
      IDLE: begin
        dem_req_ready_o = rst_ni && idleOpen && !pfWins;
        pf_req_ready_o  = rst_ni && idleOpen &&
                          (!dem_req_valid_i || (starveCnt_q == StarveMax));
      end
      REQ0: begin
        cache_req_valid_o = 1'b1;
        cache_req_addr_o  = line0_q;
      end
      REQ1: begin
        cache_req_valid_o = 1'b1;
        cache_req_addr_o  = line0_q + LineStep;
      end
      PF_REQ: begin
        cache_req_valid_o = 1'b1;
        cache_req_addr_o  = pfAddr_q;
      end
      WAIT0, WAIT1, DRAIN: cache_resp_ready_o = 1'b1;
      PF_WAIT: begin
        cache_resp_ready_o = 1'b1;
        pf_done_o          = cache_resp_valid_i && !flush_i;
      end
      RESP: dem_resp_valid_o = 1'b1;
      default: ;
    endcase
  end

  assign dem_resp_data_o = respData_q;
  assign dem_resp_mmio_o = respMmio_q;

endmodule
